// File: rtl/onehot_seq_decoder.sv
// onehot_seq_decoder: decodes a 4-state one-hot counter code into binary,
// tracks sequence lock (UNLOCKED -> SYNC -> LOCKED) and flags sequence and
// encoding errors. All outputs are registered (1-cycle latency).
// Optional saturating error counter: define ONEHOT_SEQ_DECODER_ERRCNT_EN.
// Without it err_cnt_out is tied to zero.
module onehot_seq_decoder #(
    parameter int LOCK_COUNT = 4,   // consecutive in-sequence codes to lock (1..15)
    parameter int LOSS_COUNT = 2    // consecutive bad codes to drop lock (1..15)
) (
    input  logic       clk,
    input  logic       reset_al_in,
    input  logic [3:0] onehot_in,
    input  logic       valid_in,
    output logic [1:0] count_out,
    output logic       count_valid_out,
    output logic       locked_out,
    output logic       wrap_out,
    output logic       seq_err_out,
    output logic       onehot_err_out,
    output logic [7:0] err_cnt_out
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_SYNC     = 2'd1,
        ST_LOCKED   = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] expected_q, expected_d;
    logic [3:0] match_q, match_d;
    logic [3:0] miss_q, miss_d;
    logic [1:0] count_q, count_d;
    logic       cval_q, cval_d;
    logic       locked_q, locked_d;
    logic       wrap_q, wrap_d;
    logic       seq_err_q, seq_err_d;
    logic       oh_err_q, oh_err_d;

    logic       code_legal;
    logic [1:0] code_idx;
    logic       in_seq;
    logic [3:0] match_inc;
    logic [3:0] miss_inc;

    // Decode the incoming code; anything other than exactly one bit set is illegal.
    always_comb begin
        code_legal = 1'b0;
        code_idx   = 2'd0;
        case (onehot_in)
            4'b0001: begin code_legal = 1'b1; code_idx = 2'd0; end
            4'b0010: begin code_legal = 1'b1; code_idx = 2'd1; end
            4'b0100: begin code_legal = 1'b1; code_idx = 2'd2; end
            4'b1000: begin code_legal = 1'b1; code_idx = 2'd3; end
            default: begin code_legal = 1'b0; code_idx = 2'd0; end
        endcase
    end

    assign in_seq    = code_legal && (onehot_in == expected_q);
    assign match_inc = match_q + 4'd1;
    assign miss_inc  = miss_q + 4'd1;

    // Next-state, counters and registered-output values; everything holds and
    // pulses stay low unless a valid code is sampled.
    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        match_d    = match_q;
        miss_d     = miss_q;
        count_d    = count_q;
        cval_d     = 1'b0;
        wrap_d     = 1'b0;
        seq_err_d  = 1'b0;
        oh_err_d   = 1'b0;

        if (valid_in) begin
            if (code_legal) begin
                count_d    = code_idx;
                cval_d     = 1'b1;
                // Next expected code is this one rotated left (s3 wraps to s0).
                expected_d = {onehot_in[2:0], onehot_in[3]};
            end else begin
                oh_err_d   = 1'b1;
            end

            case (state_q)
                ST_UNLOCKED: begin
                    if (code_legal) begin
                        match_d = 4'd1;
                        miss_d  = 4'd0;
                        state_d = (LOCK_N <= 4'd1) ? ST_LOCKED : ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (in_seq) begin
                        match_d = match_inc;
                        if (match_inc >= LOCK_N) begin
                            state_d = ST_LOCKED;
                            miss_d  = 4'd0;
                        end
                    end else if (code_legal) begin
                        // Legal but out of order: restart the run from this code.
                        match_d = 4'd1;
                    end else begin
                        match_d = 4'd0;
                        state_d = ST_UNLOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (in_seq) begin
                        miss_d = 4'd0;
                        wrap_d = (onehot_in == 4'b0001);
                    end else begin
                        // Illegal codes only raise the encoding error.
                        seq_err_d = code_legal;
                        if (miss_inc >= LOSS_N) begin
                            state_d = ST_UNLOCKED;
                            miss_d  = 4'd0;
                            match_d = 4'd0;
                        end else begin
                            miss_d  = miss_inc;
                        end
                    end
                end
                default: begin
                    state_d = ST_UNLOCKED;
                    match_d = 4'd0;
                    miss_d  = 4'd0;
                end
            endcase
        end
    end

    assign locked_d = (state_d == ST_LOCKED);

    // State and output registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            state_q    <= ST_UNLOCKED;
            expected_q <= 4'b0001;
            match_q    <= 4'd0;
            miss_q     <= 4'd0;
            count_q    <= 2'd0;
            cval_q     <= 1'b0;
            locked_q   <= 1'b0;
            wrap_q     <= 1'b0;
            seq_err_q  <= 1'b0;
            oh_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            match_q    <= match_d;
            miss_q     <= miss_d;
            count_q    <= count_d;
            cval_q     <= cval_d;
            locked_q   <= locked_d;
            wrap_q     <= wrap_d;
            seq_err_q  <= seq_err_d;
            oh_err_q   <= oh_err_d;
        end
    end

    assign count_out       = count_q;
    assign count_valid_out = cval_q;
    assign locked_out      = locked_q;
    assign wrap_out        = wrap_q;
    assign seq_err_out     = seq_err_q;
    assign onehot_err_out  = oh_err_q;

`ifdef ONEHOT_SEQ_DECODER_ERRCNT_EN
    logic [7:0] err_cnt_q;

    // Saturating error count, bumped on the same edge that raises an error pulse.
    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            err_cnt_q <= 8'd0;
        end else if ((seq_err_d || oh_err_d) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt_out = err_cnt_q;
`else
    assign err_cnt_out = 8'd0;
`endif

endmodule
